// File: rtl/register_file_nr_1w_asymm_if.sv
// Bus bundle for the register file: narrow read ports, wide window port and byte-enabled write port.
interface register_file_nr_1w_asymm_if #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_RD_A     = 2,
  parameter int ASYMM_FACTOR = 3
);
  localparam int NUM_BYTE = DATA_WIDTH / 8;

  logic [NUM_RD_A-1:0]                    ReadEnable_a;
  logic [NUM_RD_A-1:0][ADDR_WIDTH-1:0]    ReadAddr_a;
  logic [NUM_RD_A-1:0][DATA_WIDTH-1:0]    ReadData_a;
  logic                                   ReadEnable_b;
  logic                                   ReadIncr_b;
  logic [ADDR_WIDTH-1:0]                  ReadAddr_b;
  logic                                   WrapMode_b;
  logic [ASYMM_FACTOR*DATA_WIDTH-1:0]     ReadData_b;
  logic                                   PtrWrap_b;
  logic                                   WriteEnable;
  logic [ADDR_WIDTH-1:0]                  WriteAddr;
  logic [NUM_BYTE-1:0][7:0]               WriteData;
  logic [NUM_BYTE-1:0]                    WriteBE;

  modport master (
    output ReadEnable_a, ReadAddr_a, ReadEnable_b, ReadIncr_b, ReadAddr_b, WrapMode_b,
    output WriteEnable, WriteAddr, WriteData, WriteBE,
    input  ReadData_a, ReadData_b, PtrWrap_b
  );

  modport slave (
    input  ReadEnable_a, ReadAddr_a, ReadEnable_b, ReadIncr_b, ReadAddr_b, WrapMode_b,
    input  WriteEnable, WriteAddr, WriteData, WriteBE,
    output ReadData_a, ReadData_b, PtrWrap_b
  );
endinterface

// File: rtl/register_file_nr_1w_asymm.sv
// Flip-flop register file: byte-enabled write, 1-cycle narrow reads, combinational wide window
// behind a registered auto-advancing pointer; no backpressure, every request is accepted.
module register_file_nr_1w_asymm #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_BYTE     = DATA_WIDTH / 8,
  parameter int NUM_RD_A     = 2,
  parameter int ASYMM_FACTOR = 3,
  parameter int BYPASS       = 1
) (
  input logic clk,
  input logic rst_n,
  register_file_nr_1w_asymm_if.slave bus
);
  localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] STEP = (ADDR_WIDTH + 1)'(ASYMM_FACTOR);

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_word [NUM_RD_A];
  logic [DATA_WIDTH-1:0] rd_q    [NUM_RD_A];
  logic [ADDR_WIDTH-1:0] ptr_b;
  logic [ADDR_WIDTH:0]   ptr_sum;
  logic                  wrap_q;
  logic [ASYMM_FACTOR*DATA_WIDTH-1:0] wide_flat;

  // Word as it will look after this edge's write: enabled lanes new, others old.
  always_comb begin
    wr_merged = mem[bus.WriteAddr];
    for (int j = 0; j < NUM_BYTE; j++) begin
      if (bus.WriteBE[j]) wr_merged[j*8 +: 8] = bus.WriteData[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
    end else if (bus.WriteEnable) begin
      mem[bus.WriteAddr] <= wr_merged;
    end
  end

  always_comb begin
    for (int n = 0; n < NUM_RD_A; n++) begin
      rd_word[n] = mem[bus.ReadAddr_a[n]];
      if ((BYPASS != 0) && bus.WriteEnable && (bus.WriteAddr == bus.ReadAddr_a[n]))
        rd_word[n] = wr_merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_RD_A; n++) rd_q[n] <= '0;
    end else begin
      for (int n = 0; n < NUM_RD_A; n++) begin
        if (bus.ReadEnable_a[n]) rd_q[n] <= rd_word[n];
      end
    end
  end

  always_comb begin
    for (int n = 0; n < NUM_RD_A; n++) bus.ReadData_a[n] = rd_q[n];
  end

  // One extra bit keeps the carry so the wrap flag and modulo are exact.
  assign ptr_sum = {1'b0, ptr_b} + STEP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_b  <= '0;
      wrap_q <= 1'b0;
    end else if (bus.ReadEnable_b) begin
      ptr_b  <= bus.ReadAddr_b;
      wrap_q <= 1'b0;
    end else if (bus.ReadIncr_b) begin
      ptr_b  <= ptr_sum[ADDR_WIDTH-1:0];
      wrap_q <= ptr_sum[ADDR_WIDTH];
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign bus.PtrWrap_b = wrap_q;

  always_comb begin
    logic [ADDR_WIDTH:0] idx;
    wide_flat = '0;
    for (int k = 0; k < ASYMM_FACTOR; k++) begin
      idx = {1'b0, ptr_b} + (ADDR_WIDTH + 1)'(k);
      if (!idx[ADDR_WIDTH] || bus.WrapMode_b)
        wide_flat[k*DATA_WIDTH +: DATA_WIDTH] = mem[idx[ADDR_WIDTH-1:0]];
    end
  end

  assign bus.ReadData_b = wide_flat;
endmodule

// File: tb/tb_register_file_nr_1w_asymm.sv
// Directed bench: BYPASS=1 and BYPASS=0 instances share stimulus; narrow reads table-driven, window and reset hand-sequenced.
module tb_register_file_nr_1w_asymm;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int AF = 3;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  register_file_nr_1w_asymm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD_A(NR), .ASYMM_FACTOR(AF)) bus1 ();
  register_file_nr_1w_asymm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD_A(NR), .ASYMM_FACTOR(AF)) bus0 ();

  assign bus0.ReadEnable_a = bus1.ReadEnable_a;
  assign bus0.ReadAddr_a   = bus1.ReadAddr_a;
  assign bus0.ReadEnable_b = bus1.ReadEnable_b;
  assign bus0.ReadIncr_b   = bus1.ReadIncr_b;
  assign bus0.ReadAddr_b   = bus1.ReadAddr_b;
  assign bus0.WrapMode_b   = bus1.WrapMode_b;
  assign bus0.WriteEnable  = bus1.WriteEnable;
  assign bus0.WriteAddr    = bus1.WriteAddr;
  assign bus0.WriteData    = bus1.WriteData;
  assign bus0.WriteBE      = bus1.WriteBE;

  register_file_nr_1w_asymm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD_A(NR), .ASYMM_FACTOR(AF), .BYPASS(1))
    dut_byp (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  register_file_nr_1w_asymm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD_A(NR), .ASYMM_FACTOR(AF), .BYPASS(0))
    dut_nob (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

  typedef struct {
    logic        we;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [1:0]  ren;
    logic [2:0]  ra0;
    logic [2:0]  ra1;
    logic [31:0] e0;   // bypass instance, port 0
    logic [31:0] e1;
    logic [31:0] n0;   // no-bypass instance, port 0
    logic [31:0] n1;
  } vec_t;

  localparam int NVEC = 15;
  vec_t tbl [NVEC];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk96(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic idle();
    bus1.ReadEnable_a = '0;
    bus1.ReadAddr_a   = '0;
    bus1.ReadEnable_b = 1'b0;
    bus1.ReadIncr_b   = 1'b0;
    bus1.ReadAddr_b   = '0;
    bus1.WriteEnable  = 1'b0;
    bus1.WriteAddr    = '0;
    bus1.WriteData    = '0;
    bus1.WriteBE      = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 3'(i), 32'h1111_1111 * i, 4'hF, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[8]  = '{1'b0, 3'd0, 32'h0,         4'h0, 2'b11, 3'd5, 3'd2, 32'h5555_5555, 32'h2222_2222, 32'h5555_5555, 32'h2222_2222};
    tbl[9]  = '{1'b1, 3'd3, 32'hAABB_CCDD, 4'h5, 2'b01, 3'd3, 3'd0, 32'h33BB_33DD, 32'h2222_2222, 32'h3333_3333, 32'h2222_2222};
    tbl[10] = '{1'b0, 3'd0, 32'h0,         4'h0, 2'b11, 3'd3, 3'd3, 32'h33BB_33DD, 32'h33BB_33DD, 32'h33BB_33DD, 32'h33BB_33DD};
    tbl[11] = '{1'b1, 3'd7, 32'hFFFF_FFFF, 4'h0, 2'b01, 3'd7, 3'd0, 32'h7777_7777, 32'h33BB_33DD, 32'h7777_7777, 32'h33BB_33DD};
    tbl[12] = '{1'b1, 3'd0, 32'hDEAD_BEEF, 4'hF, 2'b00, 3'd0, 3'd0, 32'h7777_7777, 32'h33BB_33DD, 32'h7777_7777, 32'h33BB_33DD};
    tbl[13] = '{1'b1, 3'd0, 32'h1234_5678, 4'h2, 2'b11, 3'd0, 3'd0, 32'hDEAD_56EF, 32'hDEAD_56EF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[14] = '{1'b0, 3'd0, 32'h0,         4'h0, 2'b11, 3'd0, 3'd0, 32'hDEAD_56EF, 32'hDEAD_56EF, 32'hDEAD_56EF, 32'hDEAD_56EF};

    idle();
    bus1.WrapMode_b = 1'b1;
    #12;
    chk32("reset rd_a0", bus1.ReadData_a[0], 32'h0);
    chk32("reset rd_a1", bus1.ReadData_a[1], 32'h0);
    chk96("reset rd_b", bus1.ReadData_b, 96'h0);
    chk1("reset wrap", bus1.PtrWrap_b, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Narrow port table
    @(posedge clk);
    #1;
    for (int v = 0; v < NVEC; v++) begin
      bus1.WriteEnable     = tbl[v].we;
      bus1.WriteAddr       = tbl[v].waddr;
      bus1.WriteData       = tbl[v].wdata;
      bus1.WriteBE         = tbl[v].be;
      bus1.ReadEnable_a    = tbl[v].ren;
      bus1.ReadAddr_a[0]   = tbl[v].ra0;
      bus1.ReadAddr_a[1]   = tbl[v].ra1;
      tick();
      chk32($sformatf("vec%0d byp rd_a0", v), bus1.ReadData_a[0], tbl[v].e0);
      chk32($sformatf("vec%0d byp rd_a1", v), bus1.ReadData_a[1], tbl[v].e1);
      chk32($sformatf("vec%0d nob rd_a0", v), bus0.ReadData_a[0], tbl[v].n0);
      chk32($sformatf("vec%0d nob rd_a1", v), bus0.ReadData_a[1], tbl[v].n1);
    end
    idle();
    // mem now: 0=DEAD56EF 1=11111111 2=22222222 3=33BB33DD 4..7=i*11111111

    // Window at 6: wrap vs zero-fill past the top word
    bus1.ReadEnable_b = 1'b1;
    bus1.ReadAddr_b   = 3'd6;
    tick();
    idle();
    chk96("win6 wrap", bus1.ReadData_b, {32'hDEAD_56EF, 32'h7777_7777, 32'h6666_6666});
    bus1.WrapMode_b = 1'b0;
    #1;
    chk96("win6 zero", bus1.ReadData_b, {32'h0, 32'h7777_7777, 32'h6666_6666});
    bus1.WrapMode_b = 1'b1;

    // Load 0 then three increments: 3, 6, 1 (the last one wraps)
    bus1.ReadEnable_b = 1'b1;
    bus1.ReadAddr_b   = 3'd0;
    tick();
    idle();
    chk96("ptr0", bus1.ReadData_b, {32'h2222_2222, 32'h1111_1111, 32'hDEAD_56EF});
    chk1("ptr0 wrap", bus1.PtrWrap_b, 1'b0);
    bus1.ReadIncr_b = 1'b1;
    tick();
    chk96("ptr3", bus1.ReadData_b, {32'h5555_5555, 32'h4444_4444, 32'h33BB_33DD});
    chk1("ptr3 wrap", bus1.PtrWrap_b, 1'b0);
    tick();
    chk96("ptr6", bus1.ReadData_b, {32'hDEAD_56EF, 32'h7777_7777, 32'h6666_6666});
    chk1("ptr6 wrap", bus1.PtrWrap_b, 1'b0);
    tick();
    bus1.ReadIncr_b = 1'b0;
    chk96("ptr1", bus1.ReadData_b, {32'h33BB_33DD, 32'h2222_2222, 32'h1111_1111});
    chk1("ptr1 wrap", bus1.PtrWrap_b, 1'b1);
    tick();
    chk1("hold wrap", bus1.PtrWrap_b, 1'b0);
    chk96("hold ptr1", bus1.ReadData_b, {32'h33BB_33DD, 32'h2222_2222, 32'h1111_1111});

    // Load beats increment on the same edge (increment from 6 would give 1 with wrap)
    bus1.ReadEnable_b = 1'b1;
    bus1.ReadAddr_b   = 3'd6;
    tick();
    bus1.ReadAddr_b   = 3'd4;
    bus1.ReadIncr_b   = 1'b1;
    tick();
    idle();
    chk96("load prio", bus1.ReadData_b, {32'h6666_6666, 32'h5555_5555, 32'h4444_4444});
    chk1("load prio wrap", bus1.PtrWrap_b, 1'b0);

    // 4 -> 7 -> 2 (wraps), then reset mid-cycle during the wrap pulse
    bus1.ReadIncr_b = 1'b1;
    tick();
    tick();
    bus1.ReadIncr_b = 1'b0;
    chk1("pre-rst wrap", bus1.PtrWrap_b, 1'b1);
    chk96("ptr2", bus1.ReadData_b, {32'h4444_4444, 32'h33BB_33DD, 32'h2222_2222});
    #2;
    rst_n = 1'b0;
    #1;
    chk32("async rd_a0", bus1.ReadData_a[0], 32'h0);
    chk32("async rd_a1", bus1.ReadData_a[1], 32'h0);
    chk32("async nob rd_a0", bus0.ReadData_a[0], 32'h0);
    chk96("async rd_b", bus1.ReadData_b, 96'h0);
    chk1("async wrap", bus1.PtrWrap_b, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // After release every read is zero until new writes
    bus1.ReadEnable_a  = 2'b11;
    bus1.ReadAddr_a[0] = 3'd3;
    bus1.ReadAddr_a[1] = 3'd7;
    bus1.ReadEnable_b  = 1'b1;
    bus1.ReadAddr_b    = 3'd6;
    tick();
    idle();
    chk32("post rd_a0", bus1.ReadData_a[0], 32'h0);
    chk32("post rd_a1", bus1.ReadData_a[1], 32'h0);
    chk96("post rd_b", bus1.ReadData_b, 96'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/register_file_nr_1w_asymm.md
Name: register_file_nr_1w_asymm

Overview:
Parametrised flip-flop register file for FPGA targets with one byte-enabled write port. It has NUM_RD_A independent narrow read ports and one asymmetric wide read port that returns ASYMM_FACTOR consecutive words. The wide port holds a registered window pointer that can auto-advance, so a consumer can stream the file without re-issuing addresses. It supersedes the fixed 2-read variant in accelerator scratch and weight buffers.

Parameters:
ADDR_WIDTH, 5, word address width; NUM_WORDS = 2**ADDR_WIDTH
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
NUM_BYTE, DATA_WIDTH/8, byte lanes per word
NUM_RD_A, 2, number of narrow read ports (>=1)
ASYMM_FACTOR, 3, words per wide read (1..NUM_WORDS)
BYPASS, 1, 1 = narrow reads forward a same-cycle write; 0 = narrow reads return pre-write data

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ReadEnable_a  in  NUM_RD_A  per-port narrow read request
ReadAddr_a  in  NUM_RD_A x ADDR_WIDTH  per-port word address
ReadData_a  out  NUM_RD_A x DATA_WIDTH  per-port registered read data
ReadEnable_b  in  1  load wide window pointer from ReadAddr_b
ReadIncr_b  in  1  advance wide window pointer by ASYMM_FACTOR
ReadAddr_b  in  ADDR_WIDTH  wide window start address
WrapMode_b  in  1  1 = circular window; 0 = zero-fill past the top word
ReadData_b  out  ASYMM_FACTOR*DATA_WIDTH  wide read data
PtrWrap_b  out  1  pulses for one cycle when an increment wraps the pointer
WriteEnable  in  1  write request
WriteAddr  in  ADDR_WIDTH  write word address
WriteData  in  NUM_BYTE x 8  write data
WriteBE  in  NUM_BYTE  byte enables

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. Reset is honoured mid-operation: all storage, ReadData_a, the wide pointer and PtrWrap_b clear to 0 immediately.
- Write:
  - Committed on the rising edge when WriteEnable=1.
  - Only byte lanes with WriteBE[j]=1 are updated; all other lanes hold their value.
  - WriteBE=0 with WriteEnable=1 leaves the word unchanged.
- Narrow read n:
  - Latency is 1 cycle. On an edge with ReadEnable_a[n]=1, ReadData_a[n] loads mem[ReadAddr_a[n]].
  - If ReadEnable_a[n]=0, ReadData_a[n] holds its value.
  - Collision with a write to the same address on the same edge:
    - BYPASS=1: enabled bytes come from WriteData, the rest from old memory.
    - BYPASS=0: the whole word is the old memory value.
  - All ports are independent; any ports may share an address.
- Wide pointer ptr_b (registered, resets to 0):
  - ReadEnable_b=1: ptr_b <= ReadAddr_b. This has priority over ReadIncr_b.
  - Else ReadIncr_b=1: ptr_b <= (ptr_b + ASYMM_FACTOR) mod NUM_WORDS. PtrWrap_b=1 next cycle iff ptr_b + ASYMM_FACTOR >= NUM_WORDS.
  - Otherwise ptr_b holds and PtrWrap_b=0.
- Wide data:
  - Combinational from ptr_b and current storage. Valid the cycle after the pointer load or increment, and it reflects writes committed at earlier edges (no bypass).
  - Slice k, bits [k*DATA_WIDTH +: DATA_WIDTH], for k = 0..ASYMM_FACTOR-1:
    - If ptr_b+k < NUM_WORDS: mem[ptr_b+k].
    - Else, WrapMode_b=1: mem[(ptr_b+k) mod NUM_WORDS].
    - Else, WrapMode_b=0: all zeros.
  - WrapMode_b is combinational and may change at any time.
- Width rule: all address arithmetic is done ADDR_WIDTH+1 bits wide before the modulo, so there is no silent truncation.
- ASYMM_FACTOR=NUM_WORDS with WrapMode_b=1 returns the whole file rotated by ptr_b.

Test Plan:
Params ADDR_WIDTH=3, DATA_WIDTH=32, ASYMM_FACTOR=3, NUM_RD_A=2, BYPASS=1 unless noted.
1. Write mem[i]=0x1111_1111*i with WriteBE=0xF for i=0..7, then read port0 addr 5 and port1 addr 2 on the same cycle -> next cycle ReadData_a = {0x2222_2222, 0x5555_5555}.
2. With mem[3]=0x3333_3333, write 0xAABB_CCDD with WriteBE=0x5 while port0 reads addr 3 on the same edge -> ReadData_a[0]=0x33BB_33DD and mem[3]=0x33BB_33DD. Repeat with BYPASS=0 -> ReadData_a[0]=0x3333_3333.
3. Load ptr_b=6 with WrapMode_b=1 -> ReadData_b={mem[0],mem[7],mem[6]}. Set WrapMode_b=0 -> {0, mem[7], mem[6]}.
4. Load ptr_b=0, then pulse ReadIncr_b 3 times -> ptr_b = 3, 6, 1. PtrWrap_b is high only in the cycle after the third increment.
5. Assert ReadEnable_b (ReadAddr_b=4) and ReadIncr_b on the same edge -> ptr_b=4 and PtrWrap_b=0.
6. Deassert rst_n asynchronously mid-stream (between clock edges) -> ReadData_a=0, ptr_b=0 and ReadData_b=0 immediately. After release, all reads return 0 until new writes occur.
